ping_pong_ctrl: RTL and testbench

- Single-clock control stage that wraps a ping-pong buffer.
- Upstream side: accepts a valid/ready word stream and writes it into the buffer's write bank.
- Downstream side: reads the other bank back out as a valid/ready stream with a frame-last marker.
- Owns the ping_pong select and swaps banks when the write bank is closed and the read bank is fully drained.

---
 rtl/ping_pong_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ping_pong_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ping_pong_ctrl.sv
// ping_pong_ctrl: write/read control around a two-bank ping-pong buffer.
// Upstream fills one bank while downstream drains the other.
module ping_pong_ctrl #(
  parameter int BIT_LENGTH = 64,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BIT_LENGTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BIT_LENGTH-1:0] m_data,
  output logic                  m_last,
  output logic                  ena,
  output logic                  wea,
  output logic [AW-1:0]         addra,
  output logic [BIT_LENGTH-1:0] dina,
  output logic                  enb,
  output logic [AW-1:0]         addrb,
  input  logic [BIT_LENGTH-1:0] doutb,
  output logic                  ping_pong,
  output logic                  swap
);

  localparam logic [0:0] W_FILL   = 1'b0;
  localparam logic [0:0] W_FULL   = 1'b1;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_STREAM = 1'b1;

  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [AW:0]   ONE_L  = (AW + 1)'(1);

  logic [0:0]    w_state;
  logic [0:0]    r_state;
  logic [AW-1:0] wr_cnt;
  logic [AW:0]   wr_len;
  logic [AW:0]   rd_len;
  logic [AW:0]   rd_cnt;

  logic hs;
  logic close;
  logic swap_now;
  logic issue;
  logic room;
  logic rd_done;
  logic push;
  logic pop;

  logic inflight;
  logic infl_last;

  logic [BIT_LENGTH-1:0] f_data [2];
  logic [1:0]            f_last;
  logic                  f_wp;
  logic                  f_rp;
  logic [1:0]            f_cnt;
  logic [2:0]            occ;

  // ---------------- write side ----------------

  assign s_ready = (w_state == W_FILL);
  assign hs      = s_valid & s_ready;

  assign ena   = hs;
  assign wea   = hs;
  assign addra = wr_cnt;
  assign dina  = s_data;

  // A bank closes on its last slot or on an early s_last.
  assign close = hs & ((wr_cnt == LAST_A) | s_last);

  // Banks trade places only when the writer is done
  // and the reader has finished fetching its bank.
  assign swap_now = (w_state == W_FULL) &
                    (r_state == R_IDLE);

  // Write FSM: fill the write bank, then wait for a swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_FILL;
      wr_cnt  <= '0;
      wr_len  <= '0;
    end else if (swap_now) begin
      w_state <= W_FILL;
      wr_cnt  <= '0;
    end else if (hs) begin
      wr_cnt <= wr_cnt + ONE_A;
      if (close) begin
        wr_len  <= {1'b0, wr_cnt} + ONE_L;
        w_state <= W_FULL;
      end
    end
  end

  // Bank select and one-cycle swap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ping_pong <= 1'b0;
      swap      <= 1'b0;
    end else begin
      swap <= swap_now;
      if (swap_now) begin
        ping_pong <= ~ping_pong;
      end
    end
  end

  // ---------------- read side ----------------

  assign m_valid = (f_cnt != 2'd0);
  assign pop     = m_valid & m_ready;
  assign push    = inflight;

  // Slots the FIFO will hold once the pending
  // read lands; an issue now needs one free slot.
  assign occ  = {1'b0, f_cnt}
              + {2'b00, inflight}
              - {2'b00, pop};
  assign room = (occ < 3'd2);

  assign issue = (r_state == R_STREAM) &
                 (rd_cnt < rd_len) &
                 room;

  assign enb   = issue;
  assign addrb = rd_cnt[AW-1:0];

  // The bank is released once every address is
  // fetched and the last read has landed.
  assign rd_done = (r_state == R_STREAM) &
                   (rd_cnt == rd_len) &
                   ~inflight;

  // Read FSM: walk the read bank up to rd_len.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      rd_len  <= '0;
      rd_cnt  <= '0;
    end else begin
      unique case (1'b1)
        swap_now: begin
          r_state <= R_STREAM;
          rd_len  <= wr_len;
          rd_cnt  <= '0;
        end
        rd_done: begin
          r_state <= R_IDLE;
        end
        issue: begin
          rd_cnt <= rd_cnt + ONE_L;
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Track the read in flight and whether it is
  // the final word of the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight  <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      inflight  <= issue;
      infl_last <= issue & (rd_cnt == rd_len - ONE_L);
    end
  end

  // Output FIFO pointers, occupancy and last flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_wp   <= 1'b0;
      f_rp   <= 1'b0;
      f_cnt  <= 2'd0;
      f_last <= 2'b00;
    end else begin
      if (push) begin
        f_wp         <= ~f_wp;
        f_last[f_wp] <= infl_last;
      end
      if (pop) begin
        f_rp <= ~f_rp;
      end
      f_cnt <= f_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Output FIFO payload; only valid slots are read.
  always_ff @(posedge clk) begin
    if (push) begin
      f_data[f_wp] <= doutb;
    end
  end

  assign m_data = f_data[f_rp];
  assign m_last = m_valid & f_last[f_rp];

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// tb_ping_pong_ctrl: randomized bench for ping_pong_ctrl with a
// buffer model and an in-order word/frame scoreboard.
module tb_ping_pong_ctrl;

  localparam int BL    = 64;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BL-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [BL-1:0] m_data;
  logic          m_last;
  logic          ena;
  logic          wea;
  logic [AW-1:0] addra;
  logic [BL-1:0] dina;
  logic          enb;
  logic [AW-1:0] addrb;
  logic [BL-1:0] doutb;
  logic          ping_pong;
  logic          swap;

  ping_pong_ctrl #(.BIT_LENGTH(BL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb),
    .ping_pong(ping_pong), .swap(swap)
  );

  always #5 clk = ~clk;

  // Two-bank buffer: write ~ping_pong, read ping_pong, 1-cycle read.
  logic [BL-1:0] mem [2][DEPTH];
  always @(posedge clk) begin
    if (ena && wea) mem[~ping_pong][addra] <= dina;
    if (enb) doutb <= mem[ping_pong][addrb];
  end

  typedef struct packed {
    logic [BL-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  logic  il;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int beats = 0;
  int lasts = 0;
  int swaps = 0;
  int pos = 0;
  int stall_cnt = 0;
  int rdy_mode = 0;
  int beat_cyc [logic [BL-1:0]];
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  logic [BL-1:0] prev_d = '0;

  // m_ready pattern: 0 high, 1 random, 2 low, 3 toggle.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      2: m_ready = 1'b0;
      default: m_ready = ~m_ready;
    endcase
  end

  // Scoreboard: every accepted word comes out once, in order, and
  // m_last marks the end of each frame (s_last or DEPTH words).
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      pos = 0;
      swaps = 0;
      prev_v = 1'b0;
    end else begin
      if (swap) swaps++;
      n_cmp++;
      if (ping_pong !== swaps[0]) begin
        n_err++;
        $display("FAIL pp_parity: got %b want %b", ping_pong, swaps[0]);
      end
      if (s_valid && s_ready) begin
        n_cmp++;
        if (ena !== 1'b1 || wea !== 1'b1 ||
            addra !== pos[AW-1:0] || dina !== s_data) begin
          n_err++;
          $display("FAIL wr_port: ena=%b wea=%b addra=%0d want addra=%0d",
                   ena, wea, addra, pos);
        end
        il = s_last || (pos == DEPTH - 1);
        e = {s_data, il};
        exp_q.push_back(e);
        pos = il ? 0 : pos + 1;
      end else begin
        n_cmp++;
        if ((ena | wea) !== 1'b0) begin
          n_err++;
          $display("FAIL wr_idle: ena=%b wea=%b want 0", ena, wea);
        end
      end
      if (prev_v && !prev_r) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== prev_d) begin
          n_err++;
          $display("FAIL hold: m_valid=%b m_data=%h want 1 %h",
                   m_valid, m_data, prev_d);
        end
      end
      if (m_valid && m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_beat: got %h want none", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.d || m_last !== e.l) begin
            n_err++;
            $display("FAIL beat: got %h/%b want %h/%b",
                     m_data, m_last, e.d, e.l);
          end
        end
        beats++;
        if (m_last) lasts++;
        beat_cyc[m_data] = cyc;
      end
      prev_v = m_valid;
      prev_r = m_ready;
      prev_d = m_data;
    end
  end

  task automatic send_word(input logic [BL-1:0] d, input logic l);
    int t;
    logic ok;
    bit done;
    t = 0;
    done = 1'b0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    while (!done) begin
      @(negedge clk);
      ok = s_ready;
      if (!ok) stall_cnt++;
      @(posedge clk);
      #1;
      t++;
      if (ok) done = 1'b1;
      else if (t > 500) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: word %h not accepted", d);
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = {$urandom, $urandom};
  endtask

  task automatic send_frame(input logic [BL-1:0] base,
                            input int len, input bit use_last);
    for (int i = 0; i < len; i++)
      send_word(base + BL'(i), use_last && (i == len - 1));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (t >= 3000) begin
      n_err++;
      $display("FAIL drain: %0d words left want 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ping_pong, swap, enb, m_valid, m_last} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_held: pp/swap/enb/mv/ml=%b want 00000",
               {ping_pong, swap, enb, m_valid, m_last});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1 || ena !== 1'b0 || ping_pong !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: s_ready=%b ena=%b pp=%b want 1 0 0",
               s_ready, ena, ping_pong);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    int s0, b0, l0, d;
    s0 = swaps; b0 = beats; l0 = lasts;
    beat_cyc.delete();
    rdy_mode = 0;
    send_frame(0, 16, 0);
    wait_drain();
    n_cmp++;
    if (swaps - s0 != 1 || ping_pong !== 1'b1) begin
      n_err++;
      $display("FAIL full_swap: swaps=%0d pp=%b want 1 1", swaps - s0, ping_pong);
    end
    n_cmp++;
    if (beats - b0 != 16 || lasts - l0 != 1) begin
      n_err++;
      $display("FAIL full_count: beats=%0d lasts=%0d want 16 1",
               beats - b0, lasts - l0);
    end
    d = (beat_cyc.exists(64'd0) && beat_cyc.exists(64'd15)) ?
        beat_cyc[64'd15] - beat_cyc[64'd0] : -1;
    n_cmp++;
    if (d != 15) begin
      n_err++;
      $display("FAIL full_rate: span=%0d want 15", d);
    end
  endtask

  task automatic test_back_to_back();
    int s0, d;
    apply_reset();
    s0 = swaps;
    stall_cnt = 0;
    beat_cyc.delete();
    rdy_mode = 0;
    send_frame(0, 16, 0);
    send_frame(100, 16, 0);
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_bp: s_ready=%b want 0", s_ready);
    end
    @(posedge clk);
    #1;
    wait_drain();
    n_cmp++;
    if (stall_cnt < 1 || stall_cnt > 2) begin
      n_err++;
      $display("FAIL b2b_stall: stalls=%0d want 1..2", stall_cnt);
    end
    n_cmp++;
    if (swaps - s0 != 2 || ping_pong !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_swap: swaps=%0d pp=%b want 2 0", swaps - s0, ping_pong);
    end
    d = (beat_cyc.exists(64'd100) && beat_cyc.exists(64'd115)) ?
        beat_cyc[64'd115] - beat_cyc[64'd100] : -1;
    n_cmp++;
    if (d != 15) begin
      n_err++;
      $display("FAIL b2b_contig: span=%0d want 15", d);
    end
  endtask

  task automatic test_early_last();
    int s0, b0, l0;
    s0 = swaps; b0 = beats; l0 = lasts;
    rdy_mode = 0;
    send_frame(10, 5, 1);
    wait_drain();
    n_cmp++;
    if (beats - b0 != 5 || lasts - l0 != 1 || swaps - s0 != 1) begin
      n_err++;
      $display("FAIL early_last: beats=%0d lasts=%0d swaps=%0d want 5 1 1",
               beats - b0, lasts - l0, swaps - s0);
    end
    s0 = swaps; b0 = beats; l0 = lasts;
    send_word(77, 1'b1);
    send_frame(300, 16, 1);
    wait_drain();
    n_cmp++;
    if (beats - b0 != 17 || lasts - l0 != 2 || swaps - s0 != 2) begin
      n_err++;
      $display("FAIL edge_last: beats=%0d lasts=%0d swaps=%0d want 17 2 2",
               beats - b0, lasts - l0, swaps - s0);
    end
  endtask

  task automatic test_backpressure();
    int b0, l0, s0;
    apply_reset();
    b0 = beats; l0 = lasts; s0 = swaps;
    rdy_mode = 2;
    send_frame(0, 16, 0);
    send_frame(16, 16, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || beats != b0) begin
        n_err++;
        $display("FAIL stall_hold: s_ready=%b m_valid=%b beats=%0d want 0 1 0",
                 s_ready, m_valid, beats - b0);
      end
    end
    @(posedge clk);
    #1;
    rdy_mode = 3;
    wait_drain();
    rdy_mode = 0;
    n_cmp++;
    if (beats - b0 != 32 || lasts - l0 != 2 || swaps - s0 != 2) begin
      n_err++;
      $display("FAIL bp_total: beats=%0d lasts=%0d swaps=%0d want 32 2 2",
               beats - b0, lasts - l0, swaps - s0);
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    apply_reset();
    rdy_mode = 2;
    send_frame(0, 16, 0);
    send_frame(200, 7, 0);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ping_pong, swap, enb, m_valid, m_last, ena} !== 6'b0) begin
      n_err++;
      $display("FAIL mid_reset: pp/swap/enb/mv/ml/ena=%b want 000000",
               {ping_pong, swap, enb, m_valid, m_last, ena});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_release: s_ready=%b m_valid=%b want 1 0",
               s_ready, m_valid);
    end
    @(posedge clk);
    #1;
    b0 = beats;
    send_frame(50, 16, 0);
    wait_drain();
    n_cmp++;
    if (beats - b0 != 16 || ping_pong !== 1'b1) begin
      n_err++;
      $display("FAIL mid_refill: beats=%0d pp=%b want 16 1",
               beats - b0, ping_pong);
    end
  endtask

  task automatic test_random();
    int s0, b0, l0, words, frames, len;
    bit ul;
    s0 = swaps; b0 = beats; l0 = lasts;
    words = 0;
    frames = 40;
    rdy_mode = 1;
    for (int f = 0; f < frames; f++) begin
      len = $urandom_range(1, DEPTH);
      ul = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send_word({$urandom, $urandom}, ul && (i == len - 1));
        words++;
      end
    end
    wait_drain();
    rdy_mode = 0;
    n_cmp++;
    if (beats - b0 != words || lasts - l0 != frames ||
        swaps - s0 != frames) begin
      n_err++;
      $display("FAIL random: beats=%0d lasts=%0d swaps=%0d want %0d %0d %0d",
               beats - b0, lasts - l0, swaps - s0, words, frames, frames);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_early_last();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
